ps2_mouse_tracker: RTL
======================

Name: ps2_mouse_tracker

Overview:
- Upstream feeder for the rope simulation block.
- Receives the raw PS/2 mouse stream (device-to-host only), decodes standard 3-byte movement packets, and accumulates signed deltas into an absolute, screen-clamped cursor position.
- mouse_x/mouse_y drive the rope's in_mouse_x/in_mouse_y directly; these are 10-bit integer pixels, and the rope converts them to fixed point.
- Host-to-device commands (stream enable) are out of scope for this block.

Parameters:
- SCREEN_W, 640: horizontal extent; x is clamped to 0..SCREEN_W-1.
- SCREEN_H, 480: vertical extent; y is clamped to 0..SCREEN_H-1.
- INIT_X, 320: reset value of mouse_x.
- INIT_Y, 240: reset value of mouse_y.
- TIMEOUT_CYCLES, 100000: clk cycles without a PS/2 clock falling edge before a partial frame or packet is abandoned (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data; asynchronous to clk.
- mouse_x  out  10  absolute cursor x, in pixels.
- mouse_y  out  10  absolute cursor y, in pixels; 0 is the top of the screen.
- mouse_left  out  1  left button state from the last good packet.
- mouse_right  out  1  right button state from the last good packet.
- pos_update  out  1  one-cycle pulse, asserted in the same cycle new values appear.
- frame_error  out  1  one-cycle pulse on any discarded byte or packet.

Behaviour:
- Reset (async) values:
  - mouse_x=INIT_X, mouse_y=INIT_Y.
  - mouse_left=0, mouse_right=0, pos_update=0, frame_error=0.
  - Both FSMs return to their idle states; the timeout counter clears.
- Reset asserted mid-frame discards all partial data.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - A third ps2_clk flop provides falling-edge detection.
  - Data is sampled in the clk cycle where the falling edge is detected.
- Frame FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: on an edge with data=0 (start bit), clear the bit counter and go to DATA. On an edge with data=1, stay in IDLE with no error (treated as a glitch).
  - DATA: shift in 8 bits LSB-first; after the 8th bit, go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: the frame is good when odd parity over data+parity holds and the stop bit is 1. A good frame raises byte_valid one cycle later. Otherwise pulse frame_error and resync the packet FSM. Always return to IDLE.
- Packet FSM (BYTE0, BYTE1, BYTE2):
  - BYTE0: accept the byte only if bit3=1, latching flags: bit0 L, bit1 R, bit4 Xsign, bit5 Ysign, bit6 Xovf, bit7 Yovf. If bit3=0, pulse frame_error and stay in BYTE0.
  - BYTE1: latch dx. BYTE2: latch dy, then commit and return to BYTE0.
- Commit arithmetic:
  - dx = 9-bit two's complement {Xsign, byte1}; dy likewise from Ysign and byte2. If an overflow flag is set, that axis delta is 0.
  - new_x = mouse_x + dx, computed in 11-bit signed arithmetic and clamped to [0, SCREEN_W-1].
  - new_y = mouse_y − dy (PS/2 +y is up), clamped to [0, SCREEN_H-1].
  - mouse_x, mouse_y, the buttons and pos_update all update in the cycle after BYTE2's byte_valid.
- Total latency: 2 clk cycles from detection of the stop-bit edge of byte2.
- Timeout:
  - The counter clears on every ps2_clk falling edge and saturates at TIMEOUT_CYCLES.
  - If it reaches TIMEOUT_CYCLES while the frame FSM is not IDLE or the packet FSM is not BYTE0: both FSMs resync and frame_error pulses once.
  - With both FSMs idle, a timeout is silent.
- Simultaneous events: a frame error or timeout in the same cycle as a commit is impossible by construction (the commit follows STOP). A timeout takes priority over an edge that arrives in the same cycle.
- Outputs hold their values between updates.

Decomposition:
- Shared package:
  - PS/2 frame constants (8 data bits, odd parity).
  - Packet flag bit indices (L=0, R=1, ALWAYS1=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7).
  - Default screen dimensions, shared with the rope and display blocks.
- One sub-module, ps2_rx_byte: synchronizers, edge detect, frame FSM and timeout counter. It outputs byte_valid, byte[7:0], byte_error and timeout.
- The top level holds the packet FSM and the clamp/accumulate datapath.

Test Plan:
- Bench conditions: clk 50 MHz, PS/2 bit period 100 µs.
- From reset, send packet 0x09,0x05,0x03 -> mouse_left=1, mouse_x=325, mouse_y=237, and a single pos_update pulse 2 cycles after byte2's stop edge.
- From reset, send 0x18,0xF6,0x00 -> mouse_x=310, mouse_y=240.
- From reset, send 0x08,0x7F,0x00 three times -> mouse_x=447, then 574, then 639 (clamped from 701). Then send 0x28,0x00,0x00 repeatedly -> mouse_y increases by 256 per packet until it clamps at 479.
- Send 0x48,0x10,0x00 -> x unchanged (overflow), pos_update still pulses.
- Corrupt byte1's parity -> frame_error pulses with no update. The next good packet 0x08,0x01,0x00 gives x=321.
- Timeout: send byte0 only and wait TIMEOUT_CYCLES -> one frame_error pulse, and the next full packet decodes correctly.
- Mid-frame reset: assert reset during a byte -> outputs are immediately 320/240 and the following packet decodes normally.

Source files
------------

// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared PS/2 framing constants, mouse packet layout and screen defaults.
// Imported by the byte receiver and the cursor tracker.
package ps2_mouse_tracker_pkg;

  localparam int   PS2_DATA_BITS  = 8;
  localparam logic PS2_ODD_PARITY = 1'b1;

  // Byte0 flag bit positions of a standard 3-byte movement packet
  localparam int FLAG_L       = 0;
  localparam int FLAG_R       = 1;
  localparam int FLAG_ALWAYS1 = 3;
  localparam int FLAG_XSIGN   = 4;
  localparam int FLAG_YSIGN   = 5;
  localparam int FLAG_XOVF    = 6;
  localparam int FLAG_YOVF    = 7;

  localparam int DEFAULT_SCREEN_W = 640;
  localparam int DEFAULT_SCREEN_H = 480;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_e;

  typedef enum logic [1:0] {
    PKT_BYTE0 = 2'd0,
    PKT_BYTE1 = 2'd1,
    PKT_BYTE2 = 2'd2
  } pkt_state_e;

  typedef struct packed {
    logic yovf;
    logic xovf;
    logic ysign;
    logic xsign;
    logic right;
    logic left;
  } pkt_flags_t;

  // Clamp an 11-bit signed coordinate into 0..hi
  function automatic logic [9:0] clamp_coord(input logic signed [10:0] v, input int hi);
    if (v < 11'sd0) return 10'd0;
    if (int'(v) > hi) return 10'(hi);
    return v[9:0];
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: input synchronizers, falling-edge detect,
// 11-bit frame FSM and an inactivity timeout counter.
module ps2_rx_byte
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_error,
  output logic       timeout,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]   clk_sync_q;
  logic [1:0]   dat_sync_q;
  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         parity_q, parity_d;
  logic         valid_q, valid_d;
  logic         error_q, error_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic fall, bit_in, timeout_hit;

  // Bus idles high, so the synchronizers reset to 1 to avoid a phantom edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  assign fall        = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in      = dat_sync_q[1];
  assign timeout_hit = (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    if (fall)                cnt_d = '0;
    else if (cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;

    // Timeout wins over an edge arriving in the same cycle
    if (timeout_hit) begin
      state_d = FR_IDLE;
    end else if (fall) begin
      case (state_q)
        FR_IDLE: begin
          if (!bit_in) begin
            bit_cnt_d = '0;
            state_d   = FR_DATA;
          end
        end
        FR_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = FR_PARITY;
        end
        FR_PARITY: begin
          parity_d = bit_in;
          state_d  = FR_STOP;
        end
        FR_STOP: begin
          if (((^shift_q) ^ parity_q) == PS2_ODD_PARITY && bit_in) valid_d = 1'b1;
          else                                                   error_d = 1'b1;
          state_d = FR_IDLE;
        end
        default: state_d = FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FR_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_error = error_q;
  assign byte_data  = shift_q;
  assign timeout    = timeout_hit;
  assign busy       = (state_q != FR_IDLE);

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet decoder and screen-clamped absolute cursor accumulator,
// feeding integer pixel coordinates to the rope simulation.
module ps2_mouse_tracker
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int SCREEN_W       = DEFAULT_SCREEN_W,
  parameter int SCREEN_H       = DEFAULT_SCREEN_H,
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic       mouse_left,
  output logic       mouse_right,
  output logic       pos_update,
  output logic       frame_error
);

  logic       byte_valid, byte_error, rx_timeout, rx_busy;
  logic [7:0] byte_data;

  ps2_rx_byte #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_error (byte_error),
    .timeout    (rx_timeout),
    .busy       (rx_busy)
  );

  pkt_state_e pkt_q, pkt_d;
  pkt_flags_t flags_q, flags_d;
  logic [7:0] dx_q, dx_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       left_q, left_d, right_q, right_d;
  logic       upd_q, upd_d, ferr_q, ferr_d;

  logic signed [10:0] dx_s, dy_s, sum_x, sum_y;

  always_comb begin
    pkt_d   = pkt_q;
    flags_d = flags_q;
    dx_d    = dx_q;
    x_d     = x_q;
    y_d     = y_q;
    left_d  = left_q;
    right_d = right_q;
    upd_d   = 1'b0;
    ferr_d  = 1'b0;

    // dy comes straight off the wire, so the commit happens on byte2's valid
    dx_s  = flags_q.xovf ? 11'sd0 : {{3{flags_q.xsign}}, dx_q};
    dy_s  = flags_q.yovf ? 11'sd0 : {{3{flags_q.ysign}}, byte_data};
    sum_x = $signed({1'b0, x_q}) + dx_s;
    sum_y = $signed({1'b0, y_q}) - dy_s;

    if (rx_timeout) begin
      if (rx_busy || pkt_q != PKT_BYTE0) ferr_d = 1'b1;
      pkt_d = PKT_BYTE0;
    end else if (byte_error) begin
      ferr_d = 1'b1;
      pkt_d  = PKT_BYTE0;
    end else if (byte_valid) begin
      case (pkt_q)
        PKT_BYTE0: begin
          if (byte_data[FLAG_ALWAYS1]) begin
            flags_d.left  = byte_data[FLAG_L];
            flags_d.right = byte_data[FLAG_R];
            flags_d.xsign = byte_data[FLAG_XSIGN];
            flags_d.ysign = byte_data[FLAG_YSIGN];
            flags_d.xovf  = byte_data[FLAG_XOVF];
            flags_d.yovf  = byte_data[FLAG_YOVF];
            pkt_d         = PKT_BYTE1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        PKT_BYTE1: begin
          dx_d  = byte_data;
          pkt_d = PKT_BYTE2;
        end
        PKT_BYTE2: begin
          x_d     = clamp_coord(sum_x, SCREEN_W - 1);
          y_d     = clamp_coord(sum_y, SCREEN_H - 1);
          left_d  = flags_q.left;
          right_d = flags_q.right;
          upd_d   = 1'b1;
          pkt_d   = PKT_BYTE0;
        end
        default: pkt_d = PKT_BYTE0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q   <= PKT_BYTE0;
      flags_q <= '0;
      dx_q    <= '0;
      x_q     <= 10'(INIT_X);
      y_q     <= 10'(INIT_Y);
      left_q  <= 1'b0;
      right_q <= 1'b0;
      upd_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      pkt_q   <= pkt_d;
      flags_q <= flags_d;
      dx_q    <= dx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      left_q  <= left_d;
      right_q <= right_d;
      upd_q   <= upd_d;
      ferr_q  <= ferr_d;
    end
  end

  assign mouse_x     = x_q;
  assign mouse_y     = y_q;
  assign mouse_left  = left_q;
  assign mouse_right = right_q;
  assign pos_update  = upd_q;
  assign frame_error = ferr_q;

endmodule
